// File: rtl/pwm_duty_decoder.sv
// Receive side of the LED brightness PWM link: measures high time and period of
// an asynchronous PWM input and recovers the 5-step brightness level.
module pwm_duty_decoder #(
  parameter int CNT_W      = 21,
  parameter int TIMEOUT    = 1500000,
  parameter int MIN_PERIOD = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [2:0]       level,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [1:0] WAIT_RISE = 2'd0;
  localparam logic [1:0] MEAS      = 2'd1;
  localparam logic [1:0] STUCK     = 2'd2;

  localparam int PW = CNT_W + 6;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic             s1, s2, s3;
  logic             rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] per_acc;
  logic [CNT_W-1:0] hi_acc;
  logic [PW-1:0]    h40, p6, p15, p25, p35;
  logic [2:0]       level_dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Thresholds sit midway between the 5/25/50/75/100 % duty steps; compared
  // as 40*H against k*P so no divider is needed.
  assign h40 = PW'(hi_acc)  * PW'(40);
  assign p6  = PW'(per_acc) * PW'(6);
  assign p15 = PW'(per_acc) * PW'(15);
  assign p25 = PW'(per_acc) * PW'(25);
  assign p35 = PW'(per_acc) * PW'(35);

  always_comb begin
    level_dec = 3'd4;
    if (h40 < p6)       level_dec = 3'd0;
    else if (h40 < p15) level_dec = 3'd1;
    else if (h40 < p25) level_dec = 3'd2;
    else if (h40 < p35) level_dec = 3'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_RISE;
      idle_cnt   <= '0;
      per_acc    <= '0;
      hi_acc     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      level      <= 3'd0;
      valid      <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT_RISE: begin
          if (rise) begin
            state   <= MEAS;
            per_acc <= ONE_C;
            hi_acc  <= ONE_C;
          end else if (idle_cnt >= TIMEOUT_C) begin
            state    <= STUCK;
            stuck_hi <= s2;
            stuck_lo <= ~s2;
            level    <= s2 ? 3'd4 : 3'd0;
          end else begin
            idle_cnt <= idle_cnt + ONE_C;
          end
        end
        MEAS: begin
          // A rise always wins over the timeout, even on the saturating cycle.
          if (rise) begin
            if (per_acc >= MIN_C) begin
              period_cnt <= per_acc;
              high_cnt   <= hi_acc;
              level      <= level_dec;
              valid      <= 1'b1;
              stuck_hi   <= 1'b0;
              stuck_lo   <= 1'b0;
            end
            per_acc <= ONE_C;
            hi_acc  <= ONE_C;
          end else if (per_acc >= TIMEOUT_C) begin
            state    <= STUCK;
            stuck_hi <= s2;
            stuck_lo <= ~s2;
            level    <= s2 ? 3'd4 : 3'd0;
          end else begin
            per_acc <= per_acc + ONE_C;
            if (s2) hi_acc <= hi_acc + ONE_C;
          end
        end
        STUCK: begin
          if (rise) begin
            state    <= MEAS;
            per_acc  <= ONE_C;
            hi_acc   <= ONE_C;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
          end else if (fall) begin
            state    <= WAIT_RISE;
            idle_cnt <= '0;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
          end
        end
        default: state <= WAIT_RISE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: table-driven PWM segments with a
// scoreboard of expected latched results, plus hand-written stuck/glitch/reset runs.
module tb_pwm_duty_decoder;

  localparam int CNT_W      = 21;
  localparam int TB_TIMEOUT = 5000;
  localparam int MIN_PERIOD = 16;

  logic             clk;
  logic             reset_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [2:0]       level;
  logic             valid;
  logic             stuck_hi;
  logic             stuck_lo;

  typedef struct {
    int high;
    int low;
    bit exp_valid;
    int exp_level;
  } vec_t;

  typedef struct {
    int hi;
    int per;
    int lvl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[18];
  int   checks = 0;
  int   errors = 0;
  int   seen;

  pwm_duty_decoder #(
    .CNT_W(CNT_W),
    .TIMEOUT(TB_TIMEOUT),
    .MIN_PERIOD(MIN_PERIOD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pwm_in(pwm_in),
    .high_cnt(high_cnt),
    .period_cnt(period_cnt),
    .level(level),
    .valid(valid),
    .stuck_hi(stuck_hi),
    .stuck_lo(stuck_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One segment = rising edge, high for v.high cycles, low for v.low cycles.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    if (v.exp_valid) begin
      e.hi  = v.high;
      e.per = v.high + v.low;
      e.lvl = v.exp_level;
      exp_q.push_back(e);
    end
    pwm_in = 1'b1;
    waitCycles(v.high);
    pwm_in = 1'b0;
    waitCycles(v.low);
  endtask

  task automatic doReset(input logic pwm_level);
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    waitCycles(3);
    exp_q.delete();
    pwm_in = pwm_level;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic closeSequence(input string name);
    pwm_in = 1'b1;
    waitCycles(10);
    checkOutput(name, exp_q.size(), 0);
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding period.
  always @(negedge clk) begin
    if (reset_n && valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("high_cnt", int'(high_cnt), mon_e.hi);
        checkOutput("period_cnt", int'(period_cnt), mon_e.per);
        checkOutput("level", int'(level), mon_e.lvl);
      end
    end
  end

  initial begin
    tbl = '{
      '{250, 750, 1'b1, 1}, '{250, 750, 1'b1, 1}, '{250, 750, 1'b1, 1},
      '{ 50, 950, 1'b1, 0}, '{500, 500, 1'b1, 2}, '{750, 250, 1'b1, 3},
      '{149, 851, 1'b1, 0}, '{150, 850, 1'b1, 1}, '{374, 626, 1'b1, 1},
      '{375, 625, 1'b1, 2}, '{624, 376, 1'b1, 2}, '{625, 375, 1'b1, 3},
      '{874, 126, 1'b1, 3}, '{875, 125, 1'b1, 4}, '{999,   1, 1'b1, 4},
      '{  4,   4, 1'b0, 0}, '{  4,  12, 1'b1, 1}, '{  3,  12, 1'b0, 0}
    };

    pwm_in  = 1'b0;
    reset_n = 1'b0;
    waitCycles(3);
    checkOutput("reset_high_cnt", int'(high_cnt), 0);
    checkOutput("reset_period_cnt", int'(period_cnt), 0);
    checkOutput("reset_level", int'(level), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_stuck_hi", int'(stuck_hi), 0);
    checkOutput("reset_stuck_lo", int'(stuck_lo), 0);

    $display("[TB] table vectors");
    doReset(1'b0);
    waitCycles(5);
    for (int i = 0; i < 18; i++) applyStimulus(tbl[i]);
    closeSequence("table_drained");

    $display("[TB] glitch hold");
    doReset(1'b0);
    waitCycles(5);
    applyStimulus('{250, 750, 1'b1, 1});
    applyStimulus('{4, 4, 1'b0, 0});
    mon_e.hi  = 250;
    mon_e.per = 1000;
    mon_e.lvl = 1;
    exp_q.push_back(mon_e);
    pwm_in = 1'b1;
    waitCycles(20);
    checkOutput("glitch_hold_high_cnt", int'(high_cnt), 250);
    checkOutput("glitch_hold_period_cnt", int'(period_cnt), 1000);
    checkOutput("glitch_hold_level", int'(level), 1);
    waitCycles(230);
    pwm_in = 1'b0;
    waitCycles(750);
    closeSequence("glitch_drained");

    $display("[TB] stuck low");
    doReset(1'b0);
    seen = -1;
    for (int i = 1; i <= TB_TIMEOUT + 100; i++) begin
      @(posedge clk);
      #1;
      if (stuck_lo) begin
        seen = i;
        break;
      end
    end
    checkRange("stuck_lo_latency", seen, TB_TIMEOUT, TB_TIMEOUT + 4);
    checkOutput("stuck_lo_hi_flag", int'(stuck_hi), 0);
    checkOutput("stuck_lo_level", int'(level), 0);
    checkOutput("stuck_lo_period_cnt", int'(period_cnt), 0);

    $display("[TB] stuck high then 40 percent");
    doReset(1'b1);
    seen = -1;
    for (int i = 1; i <= TB_TIMEOUT + 100; i++) begin
      @(posedge clk);
      #1;
      if (stuck_hi) begin
        seen = i;
        break;
      end
    end
    checkRange("stuck_hi_latency", seen, TB_TIMEOUT, TB_TIMEOUT + 4);
    checkOutput("stuck_hi_lo_flag", int'(stuck_lo), 0);
    checkOutput("stuck_hi_level", int'(level), 4);
    pwm_in = 1'b0;
    waitCycles(5);
    checkOutput("stuck_hi_cleared", int'(stuck_hi), 0);
    checkOutput("stuck_lo_after_fall", int'(stuck_lo), 0);
    waitCycles(115);
    for (int i = 0; i < 3; i++) applyStimulus('{80, 120, 1'b1, 2});
    closeSequence("stuck_recovery_drained");

    $display("[TB] async reset mid-period");
    doReset(1'b0);
    waitCycles(5);
    applyStimulus('{250, 750, 1'b1, 1});
    applyStimulus('{250, 750, 1'b1, 1});
    pwm_in = 1'b1;
    waitCycles(100);
    checkOutput("pre_reset_period_cnt", int'(period_cnt), 1000);
    checkOutput("pre_reset_drained", exp_q.size(), 0);
    @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_high_cnt", int'(high_cnt), 0);
    checkOutput("async_reset_period_cnt", int'(period_cnt), 0);
    checkOutput("async_reset_level", int'(level), 0);
    checkOutput("async_reset_valid", int'(valid), 0);
    checkOutput("async_reset_stuck", int'(stuck_hi | stuck_lo), 0);
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    reset_n = 1'b1;
    waitCycles(20);
    applyStimulus('{500, 500, 1'b1, 2});
    applyStimulus('{500, 500, 1'b1, 2});
    closeSequence("post_reset_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
